// File: rtl/fx3_dma_pump.sv
// fx3_dma_pump: moves words from a FWFT FIFO into FX3 DMA buffers in bursts gated by the watermark flag.
// Optional partial-buffer timeout flush: define FX3_DMA_PUMP_FLUSH_TIMEOUT_EN.
`default_nettype none

module fx3_dma_pump #(
  parameter int BURST_LEN      = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ,
  input  logic        DMA_WATERMARK,
  output logic        DMA_WR,
  output logic [31:0] DMA_DATA,
  output logic        DMA_PKTEND,
  output logic        BUSY,
  output logic [31:0] WORD_CNT
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_FLAG = 3'd1;
  localparam logic [2:0] S_BURST     = 3'd2;
  localparam logic [2:0] S_FLUSH     = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             flag_meta;
  logic             flag_sync;
  logic [CNT_W-1:0] burst_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_pop;
  logic             gap_done;
  logic             timeout_hit;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      flag_meta <= 1'b0;
      flag_sync <= 1'b0;
    end else begin
      flag_meta <= DMA_WATERMARK;
      flag_sync <= flag_meta;
    end
  end

  // ENABLE gates the pop directly so a drop stops popping in the same cycle.
  assign FIFO_READ = (state == S_BURST) && ENABLE && !FIFO_EMPTY;
  assign last_pop  = FIFO_READ && (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign BUSY      = (state != S_IDLE);

`ifdef FX3_DMA_PUMP_FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive empty cycle of a partial buffer.
  assign timeout_hit = FIFO_EMPTY && (burst_cnt != '0) &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      idle_cnt <= '0;
    end else if (state != S_BURST || FIFO_READ) begin
      idle_cnt <= '0;
    end else if (FIFO_EMPTY && idle_cnt != IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (ENABLE) state_nx = S_WAIT_FLAG;
      end
      S_WAIT_FLAG: begin
        if (!ENABLE)        state_nx = S_IDLE;
        else if (flag_sync) state_nx = S_BURST;
      end
      S_BURST: begin
        if (!ENABLE)          state_nx = (burst_cnt != '0) ? S_FLUSH : S_IDLE;
        else if (last_pop)    state_nx = S_GAP;
        else if (timeout_hit) state_nx = S_FLUSH;
      end
      S_FLUSH: state_nx = S_GAP;
      S_GAP: begin
        if (gap_done) state_nx = ENABLE ? S_WAIT_FLAG : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state      <= S_IDLE;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      DMA_WR     <= 1'b0;
      DMA_DATA   <= '0;
      DMA_PKTEND <= 1'b0;
      WORD_CNT   <= '0;
    end else begin
      state <= state_nx;

      if (state != S_BURST) burst_cnt <= '0;
      else if (FIFO_READ)   burst_cnt <= burst_cnt + 1'b1;

      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;

      DMA_WR <= FIFO_READ;
      if (FIFO_READ) begin
        DMA_DATA <= FIFO_DATA;
        WORD_CNT <= WORD_CNT + 32'd1;
      end

      // FLUSH lasts one cycle, so the commit lands after any in-flight write.
      DMA_PKTEND <= (state == S_FLUSH);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fx3_dma_pump.sv
// tb_fx3_dma_pump: directed bench for fx3_dma_pump with BURST_LEN=4, GAP_CYCLES=4, TIMEOUT_CYCLES=8.
`default_nettype none

module tb_fx3_dma_pump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flag = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_read;
  logic        dma_wr;
  logic [31:0] dma_data;
  logic        pktend;
  logic        busy;
  logic [31:0] word_cnt;

  always #5 clk = ~clk;

  fx3_dma_pump #(
    .BURST_LEN      (4),
    .TIMEOUT_CYCLES (8),
    .GAP_CYCLES     (4)
  ) dut (
    .BUS_CLK       (clk),
    .BUS_RST_N     (rst_n),
    .ENABLE        (enable),
    .FIFO_EMPTY    (fifo_empty),
    .FIFO_DATA     (fifo_data),
    .FIFO_READ     (fifo_read),
    .DMA_WATERMARK (flag),
    .DMA_WR        (dma_wr),
    .DMA_DATA      (dma_data),
    .DMA_PKTEND    (pktend),
    .BUSY          (busy),
    .WORD_CNT      (word_cnt)
  );

  // FWFT FIFO model
  logic [31:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_read) rd_ptr <= rd_ptr + 1;
  end

  // Output monitor, sampled mid-cycle
  int          cyc = 0;
  int          wr_count = 0;
  int          pop_count = 0;
  int          pkt_count = 0;
  int          both_count = 0;
  int          pkt_cyc = 0;
  logic [31:0] wdata [0:63];
  int          wcyc  [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dma_wr) begin
      wdata[wr_count[5:0]] <= dma_data;
      wcyc[wr_count[5:0]]  <= cyc + 1;
      wr_count             <= wr_count + 1;
    end
    if (pktend) begin
      pkt_count <= pkt_count + 1;
      pkt_cyc   <= cyc + 1;
    end
    if (dma_wr && pktend) both_count <= both_count + 1;
    if (fifo_read) pop_count <= pop_count + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int b;
    b = 0;
    while (wr_count < n && b < budget) begin
      tick();
      b++;
    end
    if (wr_count < n) check("write_timeout", 32'(wr_count), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t0;
  int base;

  initial begin
    tick(2);
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    check("rst_dma_wr",    32'(dma_wr),    32'd0);
    check("rst_dma_data",  dma_data,       32'd0);
    check("rst_pktend",    32'(pktend),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_word_cnt",  word_cnt,       32'd0);
    rst_n = 1'b1;
    tick();

    // Full burst of 4, then flag dropped so word 5 must stay in the FIFO
    for (int i = 1; i <= 6; i++) push(32'(i));
    flag   = 1'b1;
    enable = 1'b1;
    wait_writes(1, 20);
    flag = 1'b0;
    wait_writes(4, 20);
    tick(20);
    check("burst_writes", 32'(wr_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("burst_data", wdata[i], 32'(i + 1));
      check("burst_back_to_back", 32'(wcyc[i] - wcyc[0]), 32'(i));
    end
    check("burst_word_cnt", word_cnt, 32'd4);
    check("burst_pops", 32'(pop_count), 32'd4);
    check("burst_no_pktend", 32'(pkt_count), 32'd0);

    // Flag low: parked in WAIT_FLAG with data available
    base = pop_count;
    tick(10);
    check("noflag_no_pop", 32'(pop_count), 32'(base));
    check("noflag_busy", 32'(busy), 32'd1);
    check("noflag_fifo_read", 32'(fifo_read), 32'd0);

    // Flag rise to first write: 2 sync + 1 transition + 1 register
    flag = 1'b1;
    t0   = cyc;
    wait_writes(5, 20);
    check("flag_latency", 32'(wcyc[4] - t0), 32'd4);
    check("flag_first_data", wdata[4], 32'd5);

    // Complete the buffer, then GAP (4) + WAIT_FLAG + pop before the next write
    tick(3);
    push(32'd7);
    push(32'd8);
    push(32'd9);
    wait_writes(9, 40);
    check("refill_data7", wdata[6], 32'd7);
    check("refill_data8", wdata[7], 32'd8);
    check("next_burst_data", wdata[8], 32'd9);
    check("gap_spacing", 32'(wcyc[8] - wcyc[7]), 32'd6);

    // Partial buffer with the FIFO dry
    tick(20);
`ifdef FX3_DMA_PUMP_FLUSH_TIMEOUT_EN
    check("timeout_pktend", 32'(pkt_count), 32'd1);
    check("timeout_pktend_time", 32'(pkt_cyc - wcyc[8]), 32'd9);
`else
    check("no_timeout_pktend", 32'(pkt_count), 32'd0);
`endif
    enable = 1'b0;
    tick(12);
    check("disable_pktend", 32'(pkt_count), 32'd1);
    check("disable_idle", 32'(busy), 32'd0);

    // ENABLE dropped after 2 of 4 words
    push(32'hA);
    push(32'hB);
    enable = 1'b1;
    wait_writes(11, 20);
    push(32'hC);
    push(32'hD);
    enable = 1'b0;
    tick(12);
    check("drop_writes", 32'(wr_count), 32'd11);
    check("drop_no_third_pop", 32'(wr_ptr - rd_ptr), 32'd2);
    check("drop_pktend_once", 32'(pkt_count), 32'd2);
    check("drop_idle", 32'(busy), 32'd0);
    check("never_wr_and_pktend", 32'(both_count), 32'd0);
    wr_ptr = rd_ptr;

    // Reset asserted mid-burst, between pops
    enable = 1'b1;
    push(32'hE);
    wait_writes(12, 20);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_fifo_read", 32'(fifo_read), 32'd0);
    check("midrst_dma_wr",    32'(dma_wr),    32'd0);
    check("midrst_dma_data",  dma_data,       32'd0);
    check("midrst_pktend",    32'(pktend),    32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_word_cnt",  word_cnt,       32'd0);
    base   = pkt_count;
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("midrst_no_pktend", 32'(pkt_count), 32'(base));

    // Word counter wrap
    force dut.WORD_CNT = 32'hFFFF_FFFE;
    tick();
    release dut.WORD_CNT;
    enable = 1'b1;
    push(32'h0F);
    push(32'h10);
    push(32'h11);
    wait_writes(15, 30);
    tick();
    check("word_cnt_wrap", word_cnt, 32'h0000_0001);
    check("wrap_last_data", wdata[14], 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
